next_tx_arbiter: RTL

//  Schedules all upstream traffic toward the mon_clk serial sender. Arbitrates power-on, keyboard/mouse
//  and microphone requesters into one 40-bit packet slot. Holds each packet until the sender retrieves it,
//  or drops it on timeout. Enforces a minimum idle gap between packets. Sits between the data-sync and

---
 rtl/next_tx_arbiter_if.sv | 28 ++
 rtl/next_tx_arbiter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/next_tx_arbiter_if.sv
// Signal bundle around next_tx_arbiter: source requests, retrieval pulses and the packet slot.
// slave  : the arbiter (consumes requests, drives the packet slot).
// master : the upstream sources together with the serial sender.
interface next_tx_arbiter_if;
  logic        pwr_req;
  logic        kbd_valid;
  logic        kbd_is_mouse;
  logic [15:0] kbd_data;
  logic        kbd_retrieved;
  logic        mic_valid;
  logic [31:0] mic_data;
  logic        mic_retrieved;
  logic [39:0] out_data;
  logic        out_valid;
  logic        out_retrieved;
  logic        drop_pulse;
  logic [1:0]  grant_id;

  modport slave (
    input  pwr_req, kbd_valid, kbd_is_mouse, kbd_data, mic_valid, mic_data, out_retrieved,
    output kbd_retrieved, mic_retrieved, out_data, out_valid, drop_pulse, grant_id
  );

  modport master (
    output pwr_req, kbd_valid, kbd_is_mouse, kbd_data, mic_valid, mic_data, out_retrieved,
    input  kbd_retrieved, mic_retrieved, out_data, out_valid, drop_pulse, grant_id
  );
endinterface

// File: rtl/next_tx_arbiter.sv
// Upstream packet scheduler: arbitrates power-on, keyboard/mouse and microphone
// requests into one 40-bit slot, holds it for the sender or drops it on timeout,
// then forces an idle gap before the next grant.
module next_tx_arbiter #(
  parameter logic [7:0]  HDR_POWER  = 8'h01,
  parameter logic [7:0]  HDR_KBD    = 8'h02,
  parameter logic [7:0]  HDR_MOUSE  = 8'h03,
  parameter logic [7:0]  HDR_MIC    = 8'h04,
  parameter int unsigned GAP_CYCLES = 32'd2,
  parameter int unsigned TIMEOUT    = 32'd16384,
  parameter int unsigned CNT_W      = 32'd15
) (
  input  logic             mon_clk,
  input  logic             hw_reset_n,
  next_tx_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  localparam logic [1:0]       GID_NONE     = 2'd0;
  localparam logic [1:0]       GID_PWR      = 2'd1;
  localparam logic [1:0]       GID_KBD      = 2'd2;
  localparam logic [1:0]       GID_MIC      = 2'd3;
  localparam logic [CNT_W-1:0] CNT_MAX      = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE      = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 32'd1);
  localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(GAP_CYCLES - 32'd1);
  localparam bit               TIMEOUT_EN   = (TIMEOUT != 32'd0);
  localparam bit               GAP_EN       = (GAP_CYCLES != 32'd0);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic             r_pwr_pending;
  logic             r_rr_mic;       // 1: mic goes first on a kbd/mic tie
  logic [39:0]      r_out_data;
  logic             r_out_valid;
  logic [1:0]       r_grant_id;
  logic             r_kbd_ret;
  logic             r_mic_ret;
  logic             w_grant_pwr;
  logic             w_grant_kbd;
  logic             w_grant_mic;
  logic             w_timeout;
  logic             w_drop;
  logic [39:0]      w_pkt_nxt;

  // Grant selection: only in IDLE, power first, then round-robin kbd/mic.
  always_comb begin
    w_grant_pwr = 1'b0;
    w_grant_kbd = 1'b0;
    w_grant_mic = 1'b0;
    if (r_state == ST_IDLE) begin
      if (r_pwr_pending) begin
        w_grant_pwr = 1'b1;
      end else if (bus.kbd_valid && (!r_rr_mic || !bus.mic_valid)) begin
        w_grant_kbd = 1'b1;
      end else if (bus.mic_valid) begin
        w_grant_mic = 1'b1;
      end else begin
        w_grant_pwr = 1'b0;
      end
    end else begin
      w_grant_pwr = 1'b0;
    end
  end

  // The timer value is the number of HOLD cycles already completed; the drop is
  // flagged in the last allowed cycle and suppressed if the sender takes it then.
  assign w_timeout = TIMEOUT_EN && (r_cnt == TIMEOUT_LAST);
  assign w_drop    = (r_state == ST_HOLD) && w_timeout && !bus.out_retrieved;

  // Next-state logic for IDLE -> HOLD -> GAP -> IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_grant_pwr || w_grant_kbd || w_grant_mic) begin
          w_state_nxt = ST_HOLD;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (bus.out_retrieved || w_timeout) begin
          w_state_nxt = GAP_EN ? ST_GAP : ST_IDLE;
        end else begin
          w_state_nxt = ST_HOLD;
        end
      end
      ST_GAP: begin
        if (r_cnt == GAP_LAST) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_GAP;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Packet formatting for the source being granted this cycle.
  always_comb begin
    w_pkt_nxt = r_out_data;
    if (w_grant_pwr) begin
      w_pkt_nxt = {HDR_POWER, 32'h0000_0000};
    end else if (w_grant_kbd) begin
      w_pkt_nxt = {(bus.kbd_is_mouse ? HDR_MOUSE : HDR_KBD), 16'h0000, bus.kbd_data};
    end else if (w_grant_mic) begin
      w_pkt_nxt = {HDR_MIC, bus.mic_data};
    end else begin
      w_pkt_nxt = r_out_data;
    end
  end

  // State register.
  always_ff @(posedge mon_clk or negedge hw_reset_n) begin
    if (!hw_reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Per-state cycle counter: cleared on each state change, saturates instead of wrapping.
  always_ff @(posedge mon_clk or negedge hw_reset_n) begin
    if (!hw_reset_n) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (w_state_nxt != r_state) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (r_cnt != CNT_MAX) begin
      r_cnt <= r_cnt + CNT_ONE;
    end else begin
      r_cnt <= r_cnt;
    end
  end

  // Pending power request (a new request beats a same-cycle grant) and round-robin pointer.
  always_ff @(posedge mon_clk or negedge hw_reset_n) begin
    if (!hw_reset_n) begin
      r_pwr_pending <= 1'b0;
      r_rr_mic      <= 1'b0;
    end else begin
      if (bus.pwr_req) begin
        r_pwr_pending <= 1'b1;
      end else if (w_grant_pwr) begin
        r_pwr_pending <= 1'b0;
      end else begin
        r_pwr_pending <= r_pwr_pending;
      end
      if (w_grant_kbd) begin
        r_rr_mic <= 1'b1;
      end else if (w_grant_mic) begin
        r_rr_mic <= 1'b0;
      end else begin
        r_rr_mic <= r_rr_mic;
      end
    end
  end

  // Packet slot and grant-side outputs, all valid one cycle after the grant edge.
  always_ff @(posedge mon_clk or negedge hw_reset_n) begin
    if (!hw_reset_n) begin
      r_out_data  <= 40'h00_0000_0000;
      r_out_valid <= 1'b0;
      r_grant_id  <= GID_NONE;
      r_kbd_ret   <= 1'b0;
      r_mic_ret   <= 1'b0;
    end else begin
      r_out_data  <= w_pkt_nxt;
      r_out_valid <= (w_state_nxt == ST_HOLD);
      r_kbd_ret   <= w_grant_kbd;
      r_mic_ret   <= w_grant_mic;
      if (w_grant_pwr) begin
        r_grant_id <= GID_PWR;
      end else if (w_grant_kbd) begin
        r_grant_id <= GID_KBD;
      end else if (w_grant_mic) begin
        r_grant_id <= GID_MIC;
      end else begin
        r_grant_id <= r_grant_id;
      end
    end
  end

  assign bus.out_data      = r_out_data;
  assign bus.out_valid     = r_out_valid;
  assign bus.grant_id      = r_grant_id;
  assign bus.kbd_retrieved = r_kbd_ret;
  assign bus.mic_retrieved = r_mic_ret;
  assign bus.drop_pulse    = w_drop;

endmodule
